fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that sits directly upstream of the decoder. It owns the program counter and drives the synchronous program memory (PMEM). It delivers each fetched instruction word and its PC to the decoder, and asserts the decoder's flush input after a taken jump so that wrong-path words are discarded. It supports a stall request from downstream and redirection to a jump target computed by the IALU.

## Interface
- PMEM_ADDR_WIDTH, 12: PMEM word-address width.
- PMEM_WORD_WIDTH, 16: instruction word width.
- PC_WIDTH, 12: PC width; equals PMEM_ADDR_WIDTH.
- FLUSH_CYCLES, 2: cycles `out_flush` stays high after a jump; legal range 1..7.

- clock  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- in_jump  in  1  taken-jump strobe from execute, one cycle wide.
- in_jump_target  in  PC_WIDTH  jump destination, valid when `in_jump`=1.
- in_stall  in  1  hold request from downstream.
- in_pmem_data  in  PMEM_WORD_WIDTH  PMEM read data for the address presented on the previous cycle.
- out_pmem_addr  out  PMEM_ADDR_WIDTH  PMEM read address; equals `pc_reg`.
- out_pmem_rd_en  out  1  PMEM read enable.
- out_instr  out  PMEM_WORD_WIDTH  instruction word to the decoder; 0 means NOP.
- out_pc  out  PC_WIDTH  PC of `out_instr`.
- out_flush  out  1  flush to the decoder.

## Operation
- **Registers:**
  - `pc_reg`: address fetched this cycle.
  - `inflight_pc`, `inflight_valid`: the word arriving on `in_pmem_data` this cycle.
  - `hold_instr`, `hold_pc`: capture for stall.
  - `state`: one of RUN, STALL, FLUSH.
  - `flush_cnt`: 3 bits.
- **Reset values (async):** `pc_reg`=0, `inflight_pc`=0, `inflight_valid`=0, `hold_*`=0, `state`=RUN, `flush_cnt`=0.
  - Resulting outputs: `out_instr`=0, `out_pc`=0, `out_flush`=0, `out_pmem_addr`=0, `out_pmem_rd_en`=0 while reset is high.
- **RUN:**
  - `out_pmem_rd_en`=1.
  - Each cycle: `pc_reg` ← `pc_reg`+1, modulo 2^PC_WIDTH (0xFFF wraps to 0x000); `inflight_pc` ← `pc_reg`; `inflight_valid` ← 1.
  - `out_instr` = `inflight_valid` ? `in_pmem_data` : 0.
  - `out_pc` = `inflight_pc`.
- **RUN → STALL on `in_stall`=1 (and `in_jump`=0):**
  - `hold_instr`/`hold_pc` ← the current `out_instr`/`out_pc`.
  - `pc_reg` and the inflight registers are not updated.
- **STALL:**
  - `out_pmem_rd_en`=0.
  - `out_instr`/`out_pc` driven from `hold_*`.
  - `pc_reg` frozen.
  - On `in_stall`=0: return to RUN with `out_pmem_rd_en`=1. The re-read of `inflight_pc` is not needed because `inflight_pc`+1 = `pc_reg`; the next output is `hold`, then the stream resumes at `pc_reg`.
  - Required property: no word is duplicated or skipped across a stall.
- **Jump (any state), highest priority, overrides `in_stall`:**
  - `pc_reg` ← `in_jump_target`.
  - `inflight_valid` ← 0.
  - `flush_cnt` ← FLUSH_CYCLES.
  - `state` ← FLUSH.
- **FLUSH:**
  - `out_flush`=1.
  - `out_instr`=0 and `out_pc`=`inflight_pc`.
  - Fetching continues from the target (`rd_en`=1, PC increments).
  - `flush_cnt` decrements each cycle; at 1 → RUN (or STALL if `in_stall`=1).
  - `in_stall` during FLUSH is ignored until FLUSH ends.
  - A new `in_jump` during FLUSH redirects again and reloads `flush_cnt`.
- **`out_flush`:** registered, equal to `state`==FLUSH.

## Timing
- PMEM read latency is 1 cycle: address at edge n, data at `in_pmem_data` during cycle n+1.
- Fetch-to-decoder latency: word at address A appears on `out_instr` exactly 1 cycle after `out_pmem_addr`=A with `rd_en`=1.
- **After reset release:**
  - Cycle 0: addr=0, `out_instr`=0.
  - Cycle 1: `out_instr`=PMEM[0], `out_pc`=0.
- **Jump sampled at edge n:**
  - `out_pmem_addr`=target during cycle n.
  - `out_flush`=1 for cycles n..n+FLUSH_CYCLES-1.
  - With FLUSH_CYCLES=2, the first non-flushed output is `out_instr`=PMEM[target+1] at cycle n+2. PMEM[target] itself is delivered under flush, so the jump source must target one word early. This matches the decoder's PC-relative offset convention.
- Reset asserted mid-operation: all state returns to reset values immediately (async); no partial fetch survives.

## Test plan
- **Reset/sequential fetch:** PMEM[i]=0x1000+i, release reset → `out_instr` = 0x1000, 0x1001, 0x1002… with `out_pc` = 0, 1, 2 on consecutive cycles, and `out_flush`=0.
- **Wrap-around:** jump to 0xFFE → after the flush, `out_pc` sequence 0xFFF, 0x000, 0x001 with the matching PMEM words.
- **Stall:** assert `in_stall` for 3 cycles while `out_pc`=5 → `out_pc`/`out_instr` held at 5/PMEM[5], `rd_en`=0, then 6, 7… with no gap or repeat.
- **Jump:** `in_jump`=1, target=0x040 at `out_pc`=0x010 → `out_flush`=1 for 2 cycles with `out_instr`=0, then `out_pc`=0x041.
- **Simultaneous jump+stall, and jump during flush:** jump wins; a second jump to 0x080 one cycle into FLUSH → flush extends 2 cycles from the second jump, then `out_pc`=0x081.
- **Reset mid-stall:** assert reset during STALL → all outputs 0 immediately; after release, fetch restarts at address 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - decoder/PMEM/execute-facing signal bundle of the fetch stage
interface fetch_unit_if #(
    parameter int PMEM_ADDR_WIDTH = 12,
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int PC_WIDTH        = 12
);
    logic                       in_jump;
    logic [PC_WIDTH-1:0]        in_jump_target;
    logic                       in_stall;
    logic [PMEM_WORD_WIDTH-1:0] in_pmem_data;
    logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr;
    logic                       out_pmem_rd_en;
    logic [PMEM_WORD_WIDTH-1:0] out_instr;
    logic [PC_WIDTH-1:0]        out_pc;
    logic                       out_flush;

    modport master (
        input  in_jump, in_jump_target, in_stall, in_pmem_data,
        output out_pmem_addr, out_pmem_rd_en, out_instr, out_pc, out_flush
    );

    modport slave (
        output in_jump, in_jump_target, in_stall, in_pmem_data,
        input  out_pmem_addr, out_pmem_rd_en, out_instr, out_pc, out_flush
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, PMEM read, stall hold and jump flush
module fetch_unit #(
    parameter int PMEM_ADDR_WIDTH = 12,
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int PC_WIDTH        = 12,
    parameter int FLUSH_CYCLES    = 2
) (
    input  logic          clock,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t                     state, state_nxt;
    logic [PC_WIDTH-1:0]        pc_reg, pc_nxt;
    logic [PC_WIDTH-1:0]        inflight_pc, inflight_pc_nxt;
    logic                       inflight_valid, inflight_valid_nxt;
    logic [PMEM_WORD_WIDTH-1:0] hold_instr, hold_instr_nxt;
    logic [PC_WIDTH-1:0]        hold_pc, hold_pc_nxt;
    logic [2:0]                 flush_cnt, flush_cnt_nxt;
    logic [PMEM_WORD_WIDTH-1:0] cur_instr;
    logic [PC_WIDTH-1:0]        cur_pc;
    logic                       fetch, capture;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= RUN;
            pc_reg         <= '0;
            inflight_pc    <= '0;
            inflight_valid <= 1'b0;
            hold_instr     <= '0;
            hold_pc        <= '0;
            flush_cnt      <= '0;
        end else begin
            state          <= state_nxt;
            pc_reg         <= pc_nxt;
            inflight_pc    <= inflight_pc_nxt;
            inflight_valid <= inflight_valid_nxt;
            hold_instr     <= hold_instr_nxt;
            hold_pc        <= hold_pc_nxt;
            flush_cnt      <= flush_cnt_nxt;
        end
    end

    always_comb begin
        cur_instr = '0;
        cur_pc    = inflight_pc;
        case (state)
            STALL: begin
                cur_instr = hold_instr;
                cur_pc    = hold_pc;
            end
            FLUSH:   cur_instr = '0;
            default: cur_instr = inflight_valid ? bus.in_pmem_data : '0;
        endcase
    end

    always_comb begin
        state_nxt          = state;
        pc_nxt             = pc_reg;
        inflight_pc_nxt    = inflight_pc;
        inflight_valid_nxt = inflight_valid;
        hold_instr_nxt     = hold_instr;
        hold_pc_nxt        = hold_pc;
        flush_cnt_nxt      = flush_cnt;
        fetch              = 1'b0;
        capture            = 1'b0;

        case (state)
            RUN: begin
                if (bus.in_stall) begin
                    state_nxt = STALL;
                    capture   = 1'b1;
                end else begin
                    fetch = 1'b1;
                end
            end
            STALL: begin
                // Leaving STALL re-enables the read this cycle, so the hold word
                // is followed directly by the word at pc_reg.
                if (!bus.in_stall) begin
                    state_nxt = RUN;
                    fetch     = 1'b1;
                end
            end
            default: begin
                flush_cnt_nxt = flush_cnt - 3'd1;
                if (flush_cnt <= 3'd1) begin
                    if (bus.in_stall) begin
                        // Entering STALL freezes fetch so the first post-flush word is not lost.
                        state_nxt = STALL;
                        capture   = 1'b1;
                    end else begin
                        state_nxt = RUN;
                        fetch     = 1'b1;
                    end
                end else begin
                    fetch = 1'b1;
                end
            end
        endcase

        if (fetch) begin
            pc_nxt             = pc_reg + PC_WIDTH'(1);
            inflight_pc_nxt    = pc_reg;
            inflight_valid_nxt = 1'b1;
        end
        if (capture) begin
            hold_instr_nxt = cur_instr;
            hold_pc_nxt    = cur_pc;
        end

        if (bus.in_jump) begin
            state_nxt          = FLUSH;
            pc_nxt             = bus.in_jump_target;
            inflight_pc_nxt    = pc_reg;
            inflight_valid_nxt = 1'b0;
            flush_cnt_nxt      = 3'(FLUSH_CYCLES);
            hold_instr_nxt     = hold_instr;
            hold_pc_nxt        = hold_pc;
        end
    end

    assign bus.out_pmem_addr  = PMEM_ADDR_WIDTH'(pc_reg);
    assign bus.out_pmem_rd_en = !reset && ((state != STALL) || !bus.in_stall);
    assign bus.out_instr      = cur_instr;
    assign bus.out_pc         = cur_pc;
    assign bus.out_flush      = (state == FLUSH);
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a stream-level model
module tb_fetch_unit;
    localparam int FC = 2;

    logic clock;
    logic reset;
    fetch_unit_if #(.PMEM_ADDR_WIDTH(12), .PMEM_WORD_WIDTH(16), .PC_WIDTH(12)) bus ();

    fetch_unit #(.PMEM_ADDR_WIDTH(12), .PMEM_WORD_WIDTH(16), .PC_WIDTH(12), .FLUSH_CYCLES(FC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] mem [0:4095];

    always_ff @(posedge clock) begin
        if (bus.out_pmem_rd_en) bus.in_pmem_data <= mem[bus.out_pmem_addr];
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_eval = 0;
    int n_fail = 0;

    // Decoder-visible stream: m_pc/m_instr shown now, m_next is the next word to deliver.
    int          m_flush;
    bit          m_stalled;
    logic [11:0] m_pc, m_next;
    logic [15:0] m_instr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_flush   = 0;
        m_stalled = 0;
        m_pc      = 12'h000;
        m_next    = 12'h000;
        m_instr   = 16'h0000;
    endtask

    task automatic deliver();
        m_instr = mem[m_next];
        m_pc    = m_next;
        m_next  = m_next + 12'h001;
    endtask

    task automatic advance(input logic j, input logic [11:0] t, input logic s);
        if (j) begin
            m_flush   = FC;
            m_stalled = 0;
            m_next    = t;
        end else if (m_flush > 0) begin
            if (m_flush == 1) begin
                if (s) begin
                    m_stalled = 1;
                    m_instr   = 16'h0000;
                    m_pc      = m_next - 12'h001;
                end else begin
                    deliver();
                end
            end else begin
                m_next = m_next + 12'h001;
            end
            m_flush--;
        end else if (m_stalled) begin
            if (!s) begin
                m_stalled = 0;
                deliver();
            end
        end else if (s) begin
            m_stalled = 1;
        end else begin
            deliver();
        end
    endtask

    task automatic cycle(input logic j, input logic [11:0] t, input logic s);
        bus.in_jump        = j;
        bus.in_jump_target = t;
        bus.in_stall       = s;
        #1;
        chk("flush", bus.out_flush, m_flush > 0);
        chk("rd_en", bus.out_pmem_rd_en, !(m_stalled && s));
        if (m_flush > 0) begin
            chk("flush_instr", bus.out_instr, 0);
        end else begin
            chk("instr", bus.out_instr, m_instr);
            chk("pc", bus.out_pc, m_pc);
            chk("addr", bus.out_pmem_addr, m_next);
        end
        advance(j, t, s);
        @(negedge clock);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_instr"}, bus.out_instr, 0);
        chk({tag, "_pc"}, bus.out_pc, 0);
        chk({tag, "_flush"}, bus.out_flush, 0);
        chk({tag, "_addr"}, bus.out_pmem_addr, 0);
        chk({tag, "_rd_en"}, bus.out_pmem_rd_en, 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'(16'h1000 + i);
        reset              = 1'b1;
        bus.in_jump        = 1'b0;
        bus.in_jump_target = 12'h000;
        bus.in_stall       = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_reset_outputs("reset");
        reset = 1'b0;

        // Sequential fetch up to out_pc = 5, then a 3-cycle stall there.
        repeat (6) cycle(1'b0, 12'h000, 1'b0);
        chk("seq_pc5", bus.out_pc, 12'h005);
        repeat (3) cycle(1'b0, 12'h000, 1'b1);
        repeat (4) cycle(1'b0, 12'h000, 1'b0);

        // Jump to 0x040 taken while out_pc = 0x010.
        for (int k = 0; k < 40 && m_pc != 12'h010; k++) cycle(1'b0, 12'h000, 1'b0);
        chk("jump_src_pc", m_pc, 12'h010);
        cycle(1'b1, 12'h040, 1'b0);
        repeat (4) cycle(1'b0, 12'h000, 1'b0);

        // Jump with simultaneous stall, then a second jump one cycle into FLUSH.
        cycle(1'b1, 12'h020, 1'b1);
        cycle(1'b1, 12'h080, 1'b0);
        cycle(1'b0, 12'h000, 1'b0);
        cycle(1'b0, 12'h000, 1'b0);
        chk("rejump_pc", bus.out_pc, 12'h081);
        repeat (3) cycle(1'b0, 12'h000, 1'b0);

        // Wrap-around from 0xFFE.
        cycle(1'b1, 12'hFFE, 1'b0);
        repeat (6) cycle(1'b0, 12'h000, 1'b0);

        // Stall raised on the last flush cycle.
        cycle(1'b1, 12'h100, 1'b0);
        cycle(1'b0, 12'h000, 1'b0);
        cycle(1'b0, 12'h000, 1'b1);
        cycle(1'b0, 12'h000, 1'b1);
        repeat (4) cycle(1'b0, 12'h000, 1'b0);

        for (int k = 0; k < 400; k++)
            cycle(($urandom % 16) == 0, 12'($urandom), ($urandom % 4) == 0);

        // Reset asserted during STALL.
        cycle(1'b0, 12'h000, 1'b1);
        cycle(1'b0, 12'h000, 1'b1);
        bus.in_stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        repeat (6) cycle(1'b0, 12'h000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end
endmodule
